serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller: sequences one shared full-adder cell (hw3p2) over
//  WIDTH cycles to add two WIDTH-bit operands plus carry-in, LSB first.
//  Small-area alternative to the WIDTH-cell ripple chain.
//  A start/busy/done handshake connects it to an upstream issuer.
// PARAMETERS
//  WIDTH   4   operand/sum width in bits; legal range 1..32
// PORTS
//  CLK    in   1      system clock; all state updates on the rising edge
//  RST    in   1      asynchronous, active-high reset
//  START  in   1      request; sampled only when accepting (IDLE or DONE_ST)
//  A      in   WIDTH  operand A, captured on the accepting edge
//  B      in   WIDTH  operand B, captured on the accepting edge
//  CIN    in   1      carry-in, captured on the accepting edge
//  BUSY   out  1      1 while in RUN
//  DONE   out  1      one-cycle pulse: SUM/COUT valid
//  SUM    out  WIDTH  result; held until the next result is written
//  COUT   out  1      final carry-out; held with SUM
// BEHAVIOUR
//  - Interface: one clock, CLK. Reset RST is asynchronous and active-high.
//  - Reset (asynchronous, immediate): state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0,
//    internal shift registers, carry register and bit counter = 0.
//  - FSM states: IDLE -> RUN -> DONE_ST -> IDLE. All outputs are registered/decoded
//    from state; there is no combinational path from START to the outputs.
//  - IDLE: if START=1 at edge k: a_sh<=A, b_sh<=B, c<=CIN, cnt<=0, state<=RUN.
//  - RUN, each edge: the FA takes a_sh[0], b_sh[0], c.
//    Then: sum_sh <= {S, sum_sh[WIDTH-1:1]}, c <= Cout,
//    a_sh/b_sh shift right (zero fill), cnt <= cnt+1.
//    On the edge where cnt==WIDTH-1: SUM <= {S, sum_sh[WIDTH-1:1]}, COUT <= Cout,
//    state <= DONE_ST.
//  - Latency: START is sampled at edge k. DONE is high in the cycle after edge
//    k+WIDTH and low again after edge k+WIDTH+1.
//    Throughput is one add per WIDTH+1 cycles.
//  - DONE_ST: DONE=1 for exactly one cycle.
//    START=1 here is accepted exactly as in IDLE (back-to-back): state <= RUN.
//    Otherwise state <= IDLE.
//  - START while in RUN: ignored; no queuing; the in-flight operands are unaffected.
//  - A/B/CIN may change freely after the accepting edge.
//  - SUM/COUT change only on the final RUN edge. They are never partially updated.
//  - Arithmetic: {COUT,SUM} == A + B + CIN, modulo 2^(WIDTH+1); unsigned, no overflow
//    flag.
//  - WIDTH=1: a single RUN cycle, which is also the final edge.
//  - Counter width: $clog2(WIDTH)+1 bits; it never wraps within an operation.
//  - RST mid-RUN: the operation is aborted, DONE is never pulsed, and SUM/COUT
//    return to 0.
// STRUCTURE
//  - Shared defs include: state encodings IDLE=2'd0, RUN=2'd1, DONE_ST=2'd2,
//    and WIDTH bounds.
//  - Exactly one sub-module: one hw3p2 full-adder instance (A,B,Cin -> S,Cout) as the
//    datapath. The controller holds the FSM, counter, shift and carry registers.
//  - Illegal state encoding (2'd3): returns to IDLE on the next edge.
// TESTING
//  1. Assert RST with no clock edge -> SUM=0, COUT=0, BUSY=0, DONE=0 immediately.
//  2. WIDTH=4, A=4'b0110, B=4'b1010, CIN=0, START 1 cycle
//     -> BUSY high for 4 cycles, then DONE pulse with SUM=4'b0000, COUT=1.
//  3. A=4'b1001, B=4'b1010, CIN=1 -> SUM=4'b0100, COUT=1.
//     Then A=4'b0101, B=4'b0011, CIN=0 -> SUM=4'b1000, COUT=0.
//  4. START pulsed during RUN and A changed mid-run -> result unaffected, no extra DONE.
//     START held in the DONE_ST cycle -> next op starts immediately, BUSY on the
//     following cycle.
//  5. RST asserted after 2 RUN cycles -> DONE never pulses, outputs 0.
//     A fresh START then yields the correct sum.
//  6. WIDTH=8, A=8'hFF, B=8'h00, CIN=1 -> DONE 8 cycles after the accept edge,
//     SUM=8'h00, COUT=1.
//     Random 200-op sweep vs A+B+CIN reference.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// legal operand width bounds.
package serial_add_ctrl_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  // Bit counter runs 0..WIDTH-1 and must not wrap within one operation.
  function automatic int cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bus between an issuer (master)
// and the serial adder controller (slave).
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl_hw3p2.sv
// Single full-adder cell; the controller time-multiplexes it across all bit
// positions.
module hw3p2 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one full adder LSB first for WIDTH cycles,
// then publishes {cout,sum} with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = cnt_bits(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic [WIDTH-1:0] sum_sh_next;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt_reg;
  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  hw3p2 u_fa (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .cin  (c_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
  assign sum_sh_next = (sum_sh_reg >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign accept      = bus.start && (state_reg == IDLE || state_reg == DONE_ST);
  assign last_bit    = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = bus.start ? RUN : IDLE;
      RUN:     state_next = last_bit ? DONE_ST : RUN;
      DONE_ST: state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_reg == RUN);
    bus.done = (state_reg == DONE_ST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      c_reg      <= 1'b0;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
    end else if (accept) begin
      a_sh_reg <= bus.a;
      b_sh_reg <= bus.b;
      c_reg    <= bus.cin;
      cnt_reg  <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      sum_sh_reg <= sum_sh_next;
      c_reg      <= fa_cout;
      cnt_reg    <= cnt_reg + CW'(1);
      // Result is published only once complete, never bit by bit.
      if (last_bit) begin
        sum_reg  <= sum_sh_next;
        cout_reg <= fa_cout;
      end
    end
  end

  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl at WIDTH=4 and WIDTH=8,
// checked against plain A+B+CIN arithmetic and the handshake timing rules.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(4)) if4 ();
  serial_add_ctrl_if #(.WIDTH(8)) if8 ();

  serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] last_res [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic cin);
    if (w == 4) begin
      if4.start = st; if4.a = a[3:0]; if4.b = b[3:0]; if4.cin = cin;
    end else begin
      if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin;
    end
  endtask

  // {busy, done}
  function automatic logic [1:0] flags(input int w);
    return (w == 4) ? {if4.busy, if4.done} : {if8.busy, if8.done};
  endfunction

  function automatic logic [32:0] result(input int w);
    return (w == 4) ? {28'd0, if4.cout, if4.sum} : {24'd0, if8.cout, if8.sum};
  endfunction

  // Called at a negedge; returns at the negedge where done was observed.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input bit glitch, input bit chained);
    logic [31:0] mask;
    logic [32:0] exp;
    logic [1:0]  f;
    int          idx;
    int          lat;
    int          busy_cnt;
    bit          seen;
    idx  = (w == 4) ? 0 : 1;
    mask = (32'd1 << w) - 32'd1;
    exp  = 33'(a & mask) + 33'(b & mask) + 33'(cin);
    if (chained) begin
      f = flags(w);
      check("chain_in_done", 64'(f[0]), 64'd1);
    end
    drive(w, 1'b1, a, b, cin);
    @(posedge clk);
    seen = 1'b0; busy_cnt = 0; lat = w + 5;
    for (int i = 0; i <= w + 4; i++) begin
      @(negedge clk);
      f = flags(w);
      if (i == 0) drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (glitch && i == 1) drive(w, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (glitch && i == 2) drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (f[0]) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
      if (f[1]) busy_cnt++;
      if (i == w - 1) check("sum_held", 64'(result(w)), 64'(last_res[idx]));
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(lat), 64'(w));
    check("busy_cycles", 64'(busy_cnt), 64'(w));
    check("result", 64'(result(w)), 64'(exp));
    $display("[TB] w=%0d a=%0h b=%0h cin=%0b -> {cout,sum}=%0h exp=%0h lat=%0d",
             w, a & mask, b & mask, cin, result(w), exp, lat);
    last_res[idx] = exp;
  endtask

  task automatic idle(input int w);
    logic [1:0] f;
    drive(w, 1'b0, $urandom, $urandom, 1'b0);
    @(negedge clk);
    f = flags(w);
    check("done_one_cycle", 64'(f[0]), 64'd0);
    check("idle_not_busy", 64'(f[1]), 64'd0);
  endtask

  initial begin
    bit any_done;
    bit next_chain;
    bit chained;
    int w;
    logic [1:0] f;

    drive(4, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
    last_res[0] = '0;
    last_res[1] = '0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 64'(if4.busy), 64'd0);
    check("rst_done", 64'(if4.done), 64'd0);
    check("rst_sum", 64'(if4.sum), 64'd0);
    check("rst_cout", 64'(if4.cout), 64'd0);
    check("rst_res8", 64'(result(8)), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=4 cases
    do_op(4, 32'h6, 32'hA, 1'b0, 1'b0, 1'b0); idle(4);
    do_op(4, 32'h9, 32'hA, 1'b1, 1'b0, 1'b0); idle(4);
    do_op(4, 32'h5, 32'h3, 1'b0, 1'b0, 1'b0); idle(4);

    // START during RUN ignored; then back-to-back accept from DONE_ST
    do_op(4, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0); idle(4);
    do_op(4, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    do_op(4, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1); idle(4);

    // Reset two cycles into RUN aborts the operation
    drive(4, 1'b1, 32'h7, 32'h7, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(4, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 64'(if4.busy), 64'd0);
    check("abort_done", 64'(if4.done), 64'd0);
    check("abort_res", 64'(result(4)), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res[0] = '0;
    last_res[1] = '0;
    any_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      f = flags(4);
      if (f[0]) any_done = 1'b1;
    end
    check("abort_no_done", 64'(any_done), 64'd0);
    do_op(4, 32'hB, 32'h4, 1'b1, 1'b0, 1'b0); idle(4);

    // WIDTH=8 carry ripple through all bits
    do_op(8, 32'hFF, 32'h00, 1'b1, 1'b0, 1'b0); idle(8);

    // Random sweep, with occasional back-to-back ops and mid-run START pulses
    next_chain = 1'b0;
    for (int i = 0; i < 200; i++) begin
      w = (i < 100) ? 4 : 8;
      chained = next_chain;
      do_op(w, $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), chained);
      next_chain = ($urandom_range(0, 2) == 0) && (i != 99) && (i != 199);
      if (!next_chain) idle(w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
